label_writer: RTL

Write-side sequencer for the label table. Clears every label entry after reset or on request, then accepts label definitions (LB instructions from the decoder) over a valid/ready handshake and drives the table's registered write port (`lbidw`, `typw`, `basew`, `countw`, `we`). Tracks which labels are already defined and rejects redefinitions, so the table contents always reflect the first definition since the last clear.

---
 rtl/label_writer_pkg.sv | 21 ++
 rtl/label_writer_defined_map.sv | 28 ++
 rtl/label_writer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/label_writer_pkg.sv
// Shared types and widths for the label table write-side sequencer.
package label_writer_pkg;

    localparam int LBID_W  = 12;
    localparam int TYP_W   = 6;
    localparam int BASE_W  = 16;
    localparam int COUNT_W = 16;

    localparam logic [TYP_W-1:0] TYP_UNDEF = 6'd0;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // A definition only marks its label as defined when the type is meaningful.
    function automatic logic typ_defines(input logic [TYP_W-1:0] typ);
        return (typ != TYP_UNDEF);
    endfunction

endpackage

// File: rtl/label_writer_defined_map.sv
// One bit per label id recording whether the label has been defined since the last clear.
module label_defined_map #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             set,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [IDX_W-1:0] test_idx,
    output logic             hit
);

    logic [DEPTH-1:0] bits_r;

    // Clear-all wins over a same-cycle set so a clear always leaves the map empty.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            bits_r <= {DEPTH{1'b0}};
        end else if (set) begin
            bits_r[set_idx] <= 1'b1;
        end
    end

    assign hit = bits_r[test_idx];

endmodule

// File: rtl/label_writer.sv
// Write-side sequencer for the label table: full clear, then first-definition-wins writes.
// Optional out-of-range id rejection is enabled by defining LABEL_WRITER_RANGE_CHECK_EN.
module label_writer
    import label_writer_pkg::*;
#(
    parameter int LABEL_COUNT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_req,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [LBID_W-1:0]  req_lbid,
    input  logic [TYP_W-1:0]   req_typ,
    input  logic [BASE_W-1:0]  req_base,
    input  logic [COUNT_W-1:0] req_count,
    output logic [LBID_W-1:0]  lbidw,
    output logic [TYP_W-1:0]   typw,
    output logic [BASE_W-1:0]  basew,
    output logic [COUNT_W-1:0] countw,
    output logic               we,
    output logic               busy,
`ifdef LABEL_WRITER_RANGE_CHECK_EN
    output logic               err_range,
`endif
    output logic               err_redef
);

    localparam int IDX_W     = (LABEL_COUNT > 1) ? $clog2(LABEL_COUNT) : 1;
    localparam int MAP_DEPTH = 1 << IDX_W;
    localparam int CNT_W     = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LABEL_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(LABEL_COUNT);

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [IDX_W-1:0]   idx_s;
    logic               hit_s;
    logic               map_clr_s;
    logic               map_set_s;
    logic               do_write_s;
    logic               we_s;
    logic               busy_s;
    logic               err_redef_s;
    logic [LBID_W-1:0]  lbidw_s;
    logic [TYP_W-1:0]   typw_s;
    logic [BASE_W-1:0]  basew_s;
    logic [COUNT_W-1:0] countw_s;
`ifdef LABEL_WRITER_RANGE_CHECK_EN
    logic               err_range_s;
    logic               range_bad_s;

    assign range_bad_s = ({1'b0, req_lbid} >= (LBID_W + 1)'(LABEL_COUNT));
`endif

    // Without the range check the id simply wraps at the power-of-two table span.
    assign idx_s     = req_lbid[IDX_W-1:0];
    assign req_ready = (state_r == ST_RUN) && !clear_req;

    label_defined_map #(
        .DEPTH (MAP_DEPTH),
        .IDX_W (IDX_W)
    ) u_defined_map (
        .clk      (clk),
        .reset    (reset),
        .clr      (map_clr_s),
        .set      (map_set_s),
        .set_idx  (idx_s),
        .test_idx (idx_s),
        .hit      (hit_s)
    );

    // Next-state, clear sequencing and request disposition.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        we_s        = 1'b0;
        busy_s      = busy;
        err_redef_s = 1'b0;
        lbidw_s     = lbidw;
        typw_s      = typw;
        basew_s     = basew;
        countw_s    = countw;
        map_clr_s   = 1'b0;
        map_set_s   = 1'b0;
        do_write_s  = 1'b0;
`ifdef LABEL_WRITER_RANGE_CHECK_EN
        err_range_s = 1'b0;
`endif
        case (state_r)
            ST_CLEAR: begin
                // One idle step after the last zero-write so busy drops a cycle before ready rises.
                if (cnt_r == CNT_DONE) begin
                    state_s = ST_RUN;
                    cnt_s   = {CNT_W{1'b0}};
                    busy_s  = 1'b0;
                end else begin
                    we_s     = 1'b1;
                    lbidw_s  = LBID_W'(cnt_r);
                    typw_s   = TYP_UNDEF;
                    basew_s  = {BASE_W{1'b0}};
                    countw_s = {COUNT_W{1'b0}};
                    busy_s   = (cnt_r != CNT_LAST);
                    cnt_s    = cnt_r + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_s   = ST_CLEAR;
                    cnt_s     = {CNT_W{1'b0}};
                    busy_s    = 1'b1;
                    map_clr_s = 1'b1;
                end else if (req_valid) begin
`ifdef LABEL_WRITER_RANGE_CHECK_EN
                    if (range_bad_s) begin
                        err_range_s = 1'b1;
                    end else if (hit_s) begin
                        err_redef_s = 1'b1;
                    end else begin
                        do_write_s = 1'b1;
                    end
`else
                    if (hit_s) begin
                        err_redef_s = 1'b1;
                    end else begin
                        do_write_s = 1'b1;
                    end
`endif
                end else begin
                    do_write_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_CLEAR;
                cnt_s   = {CNT_W{1'b0}};
                busy_s  = 1'b1;
            end
        endcase

        if (do_write_s) begin
            we_s      = 1'b1;
            lbidw_s   = LBID_W'(idx_s);
            typw_s    = req_typ;
            basew_s   = req_base;
            countw_s  = req_count;
            map_set_s = typ_defines(req_typ);
        end else begin
            map_set_s = 1'b0;
        end
    end

    // State, clear counter and registered table port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            cnt_r     <= {CNT_W{1'b0}};
            we        <= 1'b0;
            busy      <= 1'b1;
            err_redef <= 1'b0;
            lbidw     <= {LBID_W{1'b0}};
            typw      <= {TYP_W{1'b0}};
            basew     <= {BASE_W{1'b0}};
            countw    <= {COUNT_W{1'b0}};
`ifdef LABEL_WRITER_RANGE_CHECK_EN
            err_range <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            we        <= we_s;
            busy      <= busy_s;
            err_redef <= err_redef_s;
            lbidw     <= lbidw_s;
            typw      <= typw_s;
            basew     <= basew_s;
            countw    <= countw_s;
`ifdef LABEL_WRITER_RANGE_CHECK_EN
            err_range <= err_range_s;
`endif
        end
    end

endmodule
